// File: rtl/ddr2_read_drain_ctrl_pkg.sv
// ddr2_read_drain_ctrl_pkg: shared state encoding and burst constants
// for the DDR2 read drain controller and its output stage.
package ddr2_read_drain_ctrl_pkg;

    localparam int RING_DEPTH = 8;

    localparam logic BL4 = 1'b0;
    localparam logic BL8 = 1'b1;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CL,
        ST_LISTEN,
        ST_SETTLE,
        ST_DRAIN
    } rd_state_t;

    // Number of words in a burst for a given burst_len encoding.
    function automatic logic [3:0] bl_words(input logic bl);
        return (bl == BL8) ? 4'd8 : 4'd4;
    endfunction

endpackage

// File: rtl/ddr2_rd_out_stage.sv
// ddr2_rd_out_stage: single-entry host output register with
// valid/ready hold and a last-word flag.
module ddr2_rd_out_stage #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              last_in,
    input  logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              last,
    output logic              can_load
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;

    // Load a new word, or drop valid once the held word is consumed.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (load) begin
            data_d  = din;
            valid_d = 1'b1;
            last_d  = last_in;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign can_load = !valid_q || ready;
    assign data_out = data_q;
    assign valid    = valid_q;
    assign last     = last_q;

endmodule

// File: rtl/ddr2_read_drain_ctrl.sv
// ddr2_read_drain_ctrl: opens the ring-buffer capture window after a
// READ, then drains the captured burst onto a valid/ready host stream.
module ddr2_read_drain_ctrl
    import ddr2_read_drain_ctrl_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int PTR_W      = $clog2(RING_DEPTH),
    parameter int CL         = 5,
    parameter int LISTEN_PAD = 1,
    parameter int SETTLE     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_start,
    input  logic              burst_len,
    output logic              busy,
    output logic              err_overlap,
    output logic              listen,
    output logic [PTR_W-1:0]  readPtr,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              data_last
);

    localparam int CNT_W = 8;
    localparam int IDX_W = PTR_W + 1;

    // cnt tracks the cycle number since rd_start while waiting/listening,
    // and restarts at 1 for the settle gap.
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_START = CNT_W'(CL - LISTEN_PAD);
    localparam logic [CNT_W-1:0] L_END4  = CNT_W'(CL + 1 + LISTEN_PAD);
    localparam logic [CNT_W-1:0] L_END8  = CNT_W'(CL + 3 + LISTEN_PAD);
    localparam logic [CNT_W-1:0] SET_N   = CNT_W'(SETTLE);

    rd_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, l_end;
    logic [IDX_W-1:0] idx_q, idx_d, bl_n;
    logic [PTR_W-1:0] base_q, base_d;
    logic             bl8_q, bl8_d;
    logic             err_q, err_d;
    logic             load, last_in, can_load;

    // Next-state, counters, rolling base and output-stage load.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        base_d  = base_q;
        bl8_d   = bl8_q;
        load    = 1'b0;
        cnt_inc = cnt_q + CNT_ONE;
        bl_n    = IDX_W'(bl_words(bl8_q));
        l_end   = bl8_q ? L_END8 : L_END4;
        last_in = (idx_q == bl_n - IDX_W'(1));
        err_d   = rd_start && (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (rd_start) begin
                    bl8_d   = burst_len;
                    cnt_d   = CNT_ONE;
                    state_d = (L_START == CNT_ONE) ? ST_LISTEN : ST_WAIT_CL;
                end
            end
            ST_WAIT_CL: begin
                cnt_d = cnt_inc;
                if (cnt_inc == L_START) state_d = ST_LISTEN;
            end
            ST_LISTEN: begin
                if (cnt_q == l_end) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SET_N) begin
                    idx_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DRAIN: begin
                load = (idx_q < bl_n) && can_load;
                if (load) idx_d = idx_q + IDX_W'(1);
                if (data_valid && data_last && data_ready) begin
                    base_d  = base_q + bl_n[PTR_W-1:0];
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            base_q  <= '0;
            bl8_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            bl8_q   <= bl8_d;
            err_q   <= err_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign listen      = (state_q == ST_LISTEN);
    assign readPtr     = base_q + idx_q[PTR_W-1:0];
    assign err_overlap = err_q;

    ddr2_rd_out_stage #(
        .DATA_W (DATA_W)
    ) u_out (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .din      (dout),
        .last_in  (last_in),
        .ready    (data_ready),
        .data_out (data_out),
        .valid    (data_valid),
        .last     (data_last),
        .can_load (can_load)
    );

endmodule

// File: tb/tb_ddr2_read_drain_ctrl.sv
// tb_ddr2_read_drain_ctrl: randomized bench for the read drain
// controller against a burst-level reference model.
module tb_ddr2_read_drain_ctrl;

    localparam int CL = 5;
    localparam int LP = 1;
    localparam int ST = 2;

    logic        clk;
    logic        reset;
    logic        rd_start;
    logic        burst_len;
    logic        busy;
    logic        err_overlap;
    logic        listen;
    logic [2:0]  readPtr;
    logic [15:0] dout;
    logic [15:0] data_out;
    logic        data_valid;
    logic        data_ready;
    logic        data_last;

    logic [15:0] ring [8];
    assign dout = ring[readPtr];

    ddr2_read_drain_ctrl #(
        .DATA_W     (16),
        .PTR_W      (3),
        .CL         (CL),
        .LISTEN_PAD (LP),
        .SETTLE     (ST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_start    (rd_start),
        .burst_len   (burst_len),
        .busy        (busy),
        .err_overlap (err_overlap),
        .listen      (listen),
        .readPtr     (readPtr),
        .dout        (dout),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .data_last   (data_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int model_base = 0;

    int          obs_ptr  [8];
    logic [15:0] obs_data [8];
    logic        obs_last [8];
    int n_hs, lis_first, lis_last, lis_cnt;
    int err_cnt, err_cyc, done_cyc, stall_tot, stall_bad, val_first;
    logic busy1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ring();
        for (int i = 0; i < 8; i++) ring[i] = 16'($urandom);
    endtask

    function automatic int nominal(input bit bl8);
        int bl;
        bl = bl8 ? 8 : 4;
        return CL + bl / 2 + LP + ST + bl + 1;
    endfunction

    // Issue one READ in the current cycle and observe the whole burst.
    task automatic do_burst(input bit bl8, input int ovl, input int sa,
                            input int sb, input bit rnd);
        int cyc, st_cnt;
        bit pv, phs, pst, stl, hs;
        logic [2:0] pp, hp;
        logic [15:0] hd;
        n_hs = 0; lis_first = -1; lis_last = -1; lis_cnt = 0;
        err_cnt = 0; err_cyc = -1; done_cyc = -1; stall_tot = 0;
        stall_bad = 0; val_first = -1; busy1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            obs_ptr[k] = -1; obs_data[k] = 16'hxxxx; obs_last[k] = 1'bx;
        end
        burst_len = bl8; rd_start = 1'b1; data_ready = 1'b1;
        cyc = 0; st_cnt = 0; pv = 0; phs = 0; pst = 0;
        pp = readPtr; hp = '0; hd = '0;
        while (done_cyc < 0 && cyc < 300) begin
            tick();
            cyc++;
            rd_start = (cyc == ovl);
            if (cyc == ovl) burst_len = ~bl8;
            if (cyc == 1) busy1 = busy;
            if (listen) begin
                if (lis_first < 0) lis_first = cyc;
                lis_last = cyc;
                lis_cnt++;
            end
            if (err_overlap) begin err_cnt++; err_cyc = cyc; end
            if (pst && (!data_valid || data_out !== hd || readPtr !== hp))
                stall_bad++;
            if (data_valid && (!pv || phs)) begin
                if (val_first < 0) val_first = cyc;
                if (n_hs < 8) obs_ptr[n_hs] = int'(pp);
                st_cnt = 0;
            end
            stl = data_valid &&
                  ((((n_hs == sa) || (n_hs == sb)) && st_cnt < 3) ||
                   (rnd && $urandom_range(0, 3) == 0));
            if (stl) begin st_cnt++; stall_tot++; hd = data_out; hp = readPtr; end
            data_ready = !stl;
            hs = data_valid && data_ready;
            if (hs) begin
                if (n_hs < 8) begin
                    obs_data[n_hs] = data_out;
                    obs_last[n_hs] = data_last;
                end
                n_hs++;
            end
            if (!busy) done_cyc = cyc;
            pv = data_valid; phs = hs; pp = readPtr; pst = stl;
        end
        rd_start = 1'b0; burst_len = 1'b0; data_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rd_start = ~rd_start;
            tick();
            n_cmp++;
            if ({busy, err_overlap, listen, readPtr, data_valid, data_last, data_out} !== '0) begin
                n_bad++;
                $display("FAIL reset_hold c%0d got busy=%b err=%b lis=%b ptr=%0d v=%b l=%b d=%h want all 0",
                         c, busy, err_overlap, listen, readPtr, data_valid, data_last, data_out);
            end
        end
        rd_start = 1'b0;
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({busy, err_overlap, listen, readPtr, data_valid, data_last, data_out} !== '0) begin
            n_bad++;
            $display("FAIL reset_release got busy=%b lis=%b ptr=%0d v=%b want 0",
                     busy, listen, readPtr, data_valid);
        end
    endtask

    task automatic test_bl8();
        for (int i = 0; i < 8; i++) ring[i] = 16'h1000 + 16'(i);
        do_burst(1'b1, -1, -1, -1, 1'b0);
        n_cmp++;
        if (lis_first !== CL - LP || lis_last !== CL + 4 - 1 + LP || lis_cnt !== 6) begin
            n_bad++;
            $display("FAIL bl8_listen got %0d..%0d n=%0d want %0d..%0d n=6",
                     lis_first, lis_last, lis_cnt, CL - LP, CL + 3 + LP);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (obs_ptr[k] !== k || obs_data[k] !== 16'h1000 + 16'(k) || obs_last[k] !== (k == 7)) begin
                n_bad++;
                $display("FAIL bl8_word%0d got ptr=%0d d=%h l=%b want ptr=%0d d=%h l=%b",
                         k, obs_ptr[k], obs_data[k], obs_last[k], k, 16'h1000 + 16'(k), k == 7);
            end
        end
        n_cmp++;
        if (n_hs !== 8 || val_first !== CL + 4 + LP + ST + 1 || done_cyc !== nominal(1'b1)) begin
            n_bad++;
            $display("FAIL bl8_timing got hs=%0d first=%0d done=%0d want 8 %0d %0d",
                     n_hs, val_first, done_cyc, CL + 4 + LP + ST + 1, nominal(1'b1));
        end
        n_cmp++;
        if (busy1 !== 1'b1 || data_valid !== 1'b0 || err_cnt !== 0) begin
            n_bad++;
            $display("FAIL bl8_flags got busy1=%b v_end=%b err=%0d want 1 0 0",
                     busy1, data_valid, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit seq [6];
        seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int b = 0; b < 6; b++) begin
            int bl;
            bl = seq[b] ? 8 : 4;
            fill_ring();
            do_burst(seq[b], -1, -1, -1, 1'b0);
            for (int k = 0; k < bl; k++) begin
                n_cmp++;
                if (obs_ptr[k] !== (model_base + k) % 8 ||
                    obs_data[k] !== ring[(model_base + k) % 8] || obs_last[k] !== (k == bl - 1)) begin
                    n_bad++;
                    $display("FAIL b2b%0d_word%0d got ptr=%0d d=%h l=%b want ptr=%0d d=%h",
                             b, k, obs_ptr[k], obs_data[k], obs_last[k],
                             (model_base + k) % 8, ring[(model_base + k) % 8]);
                end
            end
            n_cmp++;
            if (n_hs !== bl || done_cyc !== nominal(seq[b]) ||
                lis_first !== CL - LP || lis_last !== CL + bl / 2 - 1 + LP) begin
                n_bad++;
                $display("FAIL b2b%0d_shape got hs=%0d done=%0d lis=%0d..%0d want %0d %0d %0d..%0d",
                         b, n_hs, done_cyc, lis_first, lis_last, bl, nominal(seq[b]),
                         CL - LP, CL + bl / 2 - 1 + LP);
            end
            model_base = (model_base + bl) % 8;
        end
    endtask

    task automatic test_backpressure();
        fill_ring();
        do_burst(1'b1, -1, 2, 5, 1'b0);
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (obs_ptr[k] !== (model_base + k) % 8 || obs_data[k] !== ring[(model_base + k) % 8]) begin
                n_bad++;
                $display("FAIL bp_word%0d got ptr=%0d d=%h want ptr=%0d d=%h",
                         k, obs_ptr[k], obs_data[k], (model_base + k) % 8, ring[(model_base + k) % 8]);
            end
        end
        n_cmp++;
        if (n_hs !== 8 || stall_tot !== 6 || stall_bad !== 0 || done_cyc !== nominal(1'b1) + 6) begin
            n_bad++;
            $display("FAIL bp_shape got hs=%0d stalls=%0d unstable=%0d done=%0d want 8 6 0 %0d",
                     n_hs, stall_tot, stall_bad, done_cyc, nominal(1'b1) + 6);
        end
    endtask

    task automatic test_overlap();
        int extra_lis;
        fill_ring();
        do_burst(1'b1, CL + 4 + LP + ST + 2, -1, -1, 1'b0);
        n_cmp++;
        if (err_cnt !== 1 || err_cyc !== CL + 4 + LP + ST + 3) begin
            n_bad++;
            $display("FAIL ovl_err got n=%0d at=%0d want 1 at %0d",
                     err_cnt, err_cyc, CL + 4 + LP + ST + 3);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (obs_data[k] !== ring[(model_base + k) % 8] || obs_last[k] !== (k == 7)) begin
                n_bad++;
                $display("FAIL ovl_word%0d got d=%h l=%b want d=%h",
                         k, obs_data[k], obs_last[k], ring[(model_base + k) % 8]);
            end
        end
        extra_lis = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (listen !== 1'b0 || busy !== 1'b0) extra_lis++;
        end
        n_cmp++;
        if (n_hs !== 8 || lis_cnt !== 6 || done_cyc !== nominal(1'b1) || extra_lis !== 0) begin
            n_bad++;
            $display("FAIL ovl_shape got hs=%0d lis=%0d done=%0d late=%0d want 8 6 %0d 0",
                     n_hs, lis_cnt, done_cyc, extra_lis, nominal(1'b1));
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++) begin
            bit bl8;
            int bl;
            bl8 = 1'($urandom_range(0, 1));
            bl = bl8 ? 8 : 4;
            fill_ring();
            do_burst(bl8, -1, -1, -1, 1'b1);
            for (int k = 0; k < bl; k++) begin
                n_cmp++;
                if (obs_ptr[k] !== (model_base + k) % 8 ||
                    obs_data[k] !== ring[(model_base + k) % 8] || obs_last[k] !== (k == bl - 1)) begin
                    n_bad++;
                    $display("FAIL rnd%0d_word%0d got ptr=%0d d=%h l=%b want ptr=%0d d=%h",
                             b, k, obs_ptr[k], obs_data[k], obs_last[k],
                             (model_base + k) % 8, ring[(model_base + k) % 8]);
                end
            end
            n_cmp++;
            if (n_hs !== bl || stall_bad !== 0 || done_cyc !== nominal(bl8) + stall_tot ||
                lis_cnt !== bl / 2 + 2 * LP) begin
                n_bad++;
                $display("FAIL rnd%0d_shape got hs=%0d unstable=%0d done=%0d lis=%0d want %0d 0 %0d %0d",
                         b, n_hs, stall_bad, done_cyc, lis_cnt, bl,
                         nominal(bl8) + stall_tot, bl / 2 + 2 * LP);
            end
            model_base = (model_base + bl) % 8;
        end
    endtask

    task automatic test_reset_mid();
        int k, cnt;
        if (model_base == 0) begin
            fill_ring();
            do_burst(1'b0, -1, -1, -1, 1'b0);
            model_base = 4;
        end
        fill_ring();
        burst_len = 1'b1; rd_start = 1'b1; data_ready = 1'b1;
        tick();
        rd_start = 1'b0; burst_len = 1'b0;
        k = 0; cnt = 0;
        while (cnt < 3 && k < 100) begin
            if (data_valid) cnt++;
            tick();
            k++;
        end
        n_cmp++;
        if (cnt !== 3 || data_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_reach got words=%0d v=%b want 3 1", cnt, data_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, err_overlap, listen, readPtr, data_valid, data_last, data_out} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_async got busy=%b lis=%b ptr=%0d v=%b l=%b d=%h want all 0",
                     busy, listen, readPtr, data_valid, data_last, data_out);
        end
        tick();
        reset = 1'b1;
        tick();
        model_base = 0;
        fill_ring();
        do_burst(1'b0, -1, -1, -1, 1'b0);
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (obs_ptr[j] !== j || obs_data[j] !== ring[j]) begin
                n_bad++;
                $display("FAIL rst_mid_next%0d got ptr=%0d d=%h want ptr=%0d d=%h",
                         j, obs_ptr[j], obs_data[j], j, ring[j]);
            end
        end
        n_cmp++;
        if (n_hs !== 4 || done_cyc !== nominal(1'b0)) begin
            n_bad++;
            $display("FAIL rst_mid_shape got hs=%0d done=%0d want 4 %0d",
                     n_hs, done_cyc, nominal(1'b0));
        end
        model_base = 4;
    endtask

    initial begin
        reset = 1'b0; rd_start = 1'b0; burst_len = 1'b0; data_ready = 1'b1;
        for (int i = 0; i < 8; i++) ring[i] = '0;
        test_reset();
        test_bl8();
        test_back_to_back();
        test_backpressure();
        test_overlap();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
